// File: rtl/bus_port_arbiter.sv
// rtl/bus_port_arbiter.sv - two-requester round-robin arbiter in front of a single master port
// Optional watchdog under `ARB_TIMEOUT_EN` (abandons a hung slave after TIMEOUT_CYCLES).
module bus_port_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [1:0]              req,
  input  logic [1:0]              req_mode,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              gnt,
  output logic [1:0]              done,
  output logic [1:0]              err,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    m_valid,
  output logic                    m_mode,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic                    m_ready,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_COMPLETE
  } state_t;

  state_t                  state;
  logic                    last_idx;
  logic                    cur_idx;
  logic                    win_idx;
  logic                    sel_mode;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Contention goes to whoever was not served last; a lone request always wins.
  always_comb begin
    win_idx = 1'b0;
    if (req == 2'b11) win_idx = ~last_idx;
    else              win_idx = req[1];
    sel_mode  = win_idx ? req_mode[1] : req_mode[0];
    sel_addr  = win_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel_wdata = win_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic [1:0]      err_q;
  logic            wd_timeout;
  assign wd_timeout = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign err        = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign err            = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      gnt      <= 2'b00;
      done     <= 2'b00;
      m_valid  <= 1'b0;
      m_mode   <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      rdata    <= '0;
      last_idx <= 1'b1;
      cur_idx  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt   <= '0;
      err_q    <= 2'b00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 2'b00;
`ifdef ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          if ((req != 2'b00) && m_ready) begin
            cur_idx <= win_idx;
            gnt     <= win_idx ? 2'b10 : 2'b01;
            m_mode  <= sel_mode;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
            m_valid <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_valid <= 1'b0;
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!m_ready) begin
            state <= S_WAIT_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_timeout) begin
            state <= S_COMPLETE;
            done  <= gnt;
            err_q <= gnt;
          end
          wd_cnt <= wd_cnt + WD_W'(1);
`endif
        end
        S_WAIT_DONE: begin
          // Slave coming back ready is the completion; m_rdata is valid on this edge only.
          if (m_ready) begin
            state <= S_COMPLETE;
            done  <= gnt;
            if (!m_mode) rdata <= m_rdata;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_timeout) begin
            state <= S_COMPLETE;
            done  <= gnt;
            err_q <= gnt;
          end
          wd_cnt <= wd_cnt + WD_W'(1);
`endif
        end
        S_COMPLETE: begin
          done     <= 2'b00;
          gnt      <= 2'b00;
          last_idx <= cur_idx;
          state    <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
          err_q    <= 2'b00;
`endif
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_port_arbiter.sv
// tb/tb_bus_port_arbiter.sv - randomized self-checking bench for bus_port_arbiter
module tb_bus_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn;
  logic [1:0] req, req_mode;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0] gnt, done, err;
  logic [DW-1:0] rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic m_valid, m_mode, m_ready;

  bus_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .m_valid(m_valid), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: who should own the port, what it carries, what rdata holds.
  bit m_idle = 1'b1, m_after_done = 1'b0, m_in_txn = 1'b0, m_last = 1'b1;
  bit stuck = 1'b0, rand_ready = 1'b0, rd_force_en = 1'b0;
  int m_win = 0, age = 0, busy = 0, busy_sel = 0, done_cnt = 0;
  logic e_mode = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0, s_rdata = '0, rd_force = '0;
  logic [1:0] seen_err = 2'b00;
  int grant_log[$];

  task automatic step();
    logic p_rstn = rstn;
    logic [1:0] p_req = req;
    logic [1:0] p_mode = req_mode;
    logic [2*AW-1:0] p_addr = req_addr;
    logic [2*DW-1:0] p_wdata = req_wdata;
    logic p_ready = m_ready;
    @(negedge clk);
    if (!p_rstn) begin
      chk("rst_gnt", gnt, 0);   chk("rst_done", done, 0); chk("rst_err", err, 0);
      chk("rst_valid", m_valid, 0); chk("rst_mode", m_mode, 0);
      chk("rst_addr", m_addr, 0); chk("rst_wdata", m_wdata, 0);
      m_idle = 1; m_after_done = 0; m_in_txn = 0; m_last = 1; e_rdata = '0;
    end else if (m_after_done) begin
      chk("post_gnt", gnt, 0); chk("post_done", done, 0); chk("post_err", err, 0);
      chk("post_valid", m_valid, 0);
      m_after_done = 0; m_idle = 1;
    end else if (m_idle) begin
      chk("idle_done", done, 0); chk("idle_err", err, 0);
      if (p_req != 2'b00 && p_ready) begin
        m_win = (p_req == 2'b11) ? (m_last ? 0 : 1) : (p_req[1] ? 1 : 0);
        e_mode = p_mode[m_win];
        e_addr = p_addr[m_win*AW +: AW];
        e_wdata = p_wdata[m_win*DW +: DW];
        chk("grant", gnt, 32'(1) << m_win);
        chk("issue_valid", m_valid, 1);
        chk("issue_mode", m_mode, e_mode);
        chk("issue_addr", m_addr, e_addr);
        chk("issue_wdata", m_wdata, e_wdata);
        m_idle = 0; m_in_txn = 1; age = 0;
        grant_log.push_back(m_win);
        busy = (busy_sel > 0) ? busy_sel : $urandom_range(2, 5);
      end else begin
        chk("no_grant", gnt, 0);
        chk("no_valid", m_valid, 0);
      end
    end else begin
      age++;
      chk("hold_valid", m_valid, 0);
      chk("hold_gnt", gnt, 32'(1) << m_win);
      chk("hold_mode", m_mode, e_mode);
      chk("hold_addr", m_addr, e_addr);
      chk("hold_wdata", m_wdata, e_wdata);
      if (done != 2'b00) begin
        chk("done", done, 32'(1) << m_win);
        chk("done_err", err, stuck ? (32'(1) << m_win) : 32'(0));
        seen_err = err;
        if (!stuck && e_mode == 1'b0) e_rdata = s_rdata;
        done_cnt++;
        m_last = (m_win == 1);
        m_in_txn = 0; m_after_done = 1;
      end else begin
        chk("busy_err", err, 0);
        if (age == 61) chk("txn_stalled", age, 0);
      end
    end
    chk("rdata", rdata, e_rdata);
    // Slave: busy from the ISSUE cycle for busy cycles, then ready with fresh read data.
    if (stuck) begin
      m_ready = 1'b1; m_rdata = DW'($urandom);
    end else if (m_in_txn) begin
      if (busy > 0) begin
        m_ready = 1'b0; m_rdata = DW'($urandom); busy--;
      end else if (!m_ready) begin
        s_rdata = rd_force_en ? rd_force : DW'($urandom);
        m_rdata = s_rdata; m_ready = 1'b1;
      end
    end else begin
      m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    int c0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == c0; i++) step();
    chk({tag, "_done"}, done_cnt - c0, 1);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = 2'b00;
    step();
    rstn = 1'b1;
  endtask

  initial begin
    int base;
    rstn = 1'b0; req = 2'b00; req_mode = 2'b00; req_addr = '0; req_wdata = '0;
    m_ready = 1'b1; m_rdata = '0;
    step(); step();
    rstn = 1'b1;

    // write from requester 0, slave busy 3 cycles
    busy_sel = 3;
    req = 2'b01; req_mode = 2'b01; req_addr = {16'h0000, 16'h1001}; req_wdata = {8'h00, 8'hA5};
    wait_done("t042", 20);
    req = 2'b00;
    step(); step();
    chk("t042_rdata", rdata, 0);

    // read from requester 1
    rd_force_en = 1; rd_force = 8'h3C;
    req = 2'b10; req_mode = 2'b00; req_addr = {16'h2004, 16'h0000};
    wait_done("t043", 20);
    req = 2'b00;
    rd_force_en = 0;
    repeat (3) step();
    chk("t043_rdata", rdata, 8'h3C);

    // back-to-back contention after reset
    do_reset();
    base = grant_log.size();
    req = 2'b11; req_mode = 2'b11; req_addr = {16'hBEEF, 16'hCAFE}; req_wdata = {8'h22, 8'h11};
    wait_done("t044a", 20); wait_done("t044b", 20); wait_done("t044c", 20);
    req = 2'b00;
    step(); step();
    chk("t044_order0", grant_log[base], 0);
    chk("t044_order1", grant_log[base+1], 1);
    chk("t044_order2", grant_log[base+2], 0);

    // request dropped right after the grant
    req = 2'b01; req_mode = 2'b00; req_addr = {16'h0, 16'h0042};
    step();
    req = 2'b00;
    wait_done("t045", 20);
    step();

    // reset while waiting on the slave
    busy_sel = 8;
    req = 2'b10; req_mode = 2'b00; req_addr = {16'h0300, 16'h0};
    step(); step(); step(); step();
    base = done_cnt;
    do_reset();
    busy_sel = 3;
    repeat (4) step();
    chk("t046_no_done", done_cnt - base, 0);
    req = 2'b10; req_mode = 2'b01; req_wdata = {8'h5A, 8'h00};
    wait_done("t046", 20);
    req = 2'b00;
    step();

    // slave never goes busy
    stuck = 1;
    req = 2'b01; req_mode = 2'b01;
    step();
    req = 2'b00;
`ifdef ARB_TIMEOUT_EN
    wait_done("t047", 40);
    chk("t047_err", seen_err, 2'b01);
    step();
`else
    base = done_cnt;
    repeat (30) step();
    chk("t047_stuck_gnt", gnt, 2'b01);
    chk("t047_no_done", done_cnt - base, 0);
`endif
    stuck = 0;
    do_reset();

    // randomized traffic
    busy_sel = 0; rand_ready = 1;
    for (int i = 0; i < 600; i++) begin
      req = 2'($urandom); req_mode = 2'($urandom);
      req_addr = 32'($urandom); req_wdata = 16'($urandom);
      step();
    end
    req = 2'b00; rand_ready = 0;
    repeat (12) step();
    chk("rand_idle_gnt", gnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
